// File: rtl/cache_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared definitions for the cache/main-memory arbiter and its fill sequencer:
// arbiter state encoding, cache-block geometry and the fill owner encoding.
// -----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

    // Arbiter states. QUIESCE is the post-reset drain window.
    typedef enum logic [2:0] {
        QUIESCE = 3'd0,
        IDLE    = 3'd1,
        STORE   = 3'd2,
        FILL_D  = 3'd3,
        FILL_I  = 3'd4,
        DONE    = 3'd5
    } arbState_t;

    // Which cache a fill belongs to.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Words per cache block and the width of a word index within the block.
    localparam int WORDS = 8;
    localparam int WIDX  = $clog2(WORDS);

    // Clears the byte offset within a 16-byte block.
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_mem_arbiter_fill_sequencer.sv
// -----------------------------------------------------------------------------
// fill_sequencer
// Runs one cache-block fill: issues WORDS back-to-back word reads starting at
// the latched block base and steers each returned word into the owning cache
// with its word index.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             load base/owner and clear counters (arbiter leaving IDLE)
//   active            arbiter is in a fill state
//   base, owner       block base address and owning cache, sampled on start
//   mem_rvalid/rdata  memory read return
//   issueEn/issueAddr read request for this cycle
//   fill_data/word    returned word and its index within the block
//   i/d_fill_we       write strobe into the owning cache
//   fillOwner         latched owner, used by the arbiter for the done pulse
//   lastWord          final word of the block is returning this cycle
// -----------------------------------------------------------------------------
module fill_sequencer
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              active,
    input  logic [ADDR_W-1:0] base,
    input  owner_t            owner,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              issueEn,
    output logic [ADDR_W-1:0] issueAddr,
    output logic [DATA_W-1:0] fill_data,
    output logic [WIDX-1:0]   fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output owner_t            fillOwner,
    output logic              lastWord
);

    // Issue counter needs one extra bit so it can sit at WORDS once all
    // reads have gone out; the return counter wraps naturally after the last.
    localparam int ICW = WIDX + 1;

    logic [ADDR_W-1:0] baseReg;
    logic [ICW-1:0]    issueCnt;
    logic [WIDX-1:0]   retCnt;
    logic              retValid;

    // Base and owner are captured once per fill; the request inputs are not
    // looked at again until the arbiter is back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baseReg   <= '0;
            fillOwner <= OWNER_I;
            issueCnt  <= '0;
            retCnt    <= '0;
        end else if (start) begin
            baseReg   <= base;
            fillOwner <= owner;
            issueCnt  <= '0;
            retCnt    <= '0;
        end else if (active) begin
            if (issueEn) begin
                issueCnt <= issueCnt + 1'b1;
            end
            if (mem_rvalid) begin
                retCnt <= retCnt + 1'b1;
            end
        end
    end

    // Word k lives at byte offset 2k; the add wraps within ADDR_W so a block
    // at the top of memory never carries out.
    always_comb begin
        issueEn   = active && (issueCnt < ICW'(WORDS));
        issueAddr = baseReg + ADDR_W'({issueCnt[WIDX-1:0], 1'b0});
    end

    // Returns are only accepted while a fill is active; stale returns that
    // drain during QUIESCE never reach a cache. Data and index are held at
    // zero outside accepted returns to keep the fill bus quiet.
    always_comb begin
        retValid  = active && mem_rvalid;
        fill_data = retValid ? mem_rdata : '0;
        fill_word = retValid ? retCnt : '0;
        i_fill_we = retValid && (fillOwner == OWNER_I);
        d_fill_we = retValid && (fillOwner == OWNER_D);
        lastWord  = retValid && (retCnt == WIDX'(WORDS - 1));
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single-port pipelined main memory between I-cache fills, D-cache
// fills and D-cache write-through stores. Fixed priority store > D fill >
// I fill; a fill in progress is never pre-empted.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_miss, i_addr                 I-cache fill request (level) and address
//   d_miss, d_addr                 D-cache fill request (level) and address
//   d_wr_req, d_wr_addr, d_wr_data write-through store request (level)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                      memory command for this cycle
//   mem_rvalid, mem_rdata          memory read return, MEM_LAT after issue
//   fill_data, fill_word           returned word and index within the block
//   i_fill_we, d_fill_we           write strobes into the cache data arrays
//   i_fill_done, d_fill_done       one-cycle fill complete pulses
//   d_wr_ack                       one-cycle pulse: store issued
//   busy                           arbiter is not IDLE
// -----------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] fill_data,
    output logic [WIDX-1:0]   fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy
);

    localparam int QCW = $clog2(MEM_LAT + 1);

    // Upper address bits kept, 4-bit block offset cleared, for any ADDR_W.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLOCK_MASK);

    arbState_t         state;
    arbState_t         nextState;
    logic [QCW-1:0]    quiesceCnt;
    logic              quiesceDone;
    logic              fillActive;
    logic              fillStart;
    owner_t            startOwner;
    logic [ADDR_W-1:0] startBase;
    logic              seqIssueEn;
    logic [ADDR_W-1:0] seqIssueAddr;
    owner_t            fillOwner;
    logic              lastWord;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= QUIESCE;
        end else begin
            state <= nextState;
        end
    end

    // Post-reset drain: reads issued before reset may still return, so the
    // arbiter waits MEM_LAT cycles before accepting new work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quiesceCnt <= '0;
        end else if (state == QUIESCE) begin
            quiesceCnt <= quiesceCnt + 1'b1;
        end else begin
            quiesceCnt <= '0;
        end
    end

    assign quiesceDone = (quiesceCnt == QCW'(MEM_LAT - 1));
    assign fillActive  = (state == FILL_D) || (state == FILL_I);

    // Fill launch decode: a fill starts from IDLE only when no store is
    // pending, with the D-cache ahead of the I-cache.
    always_comb begin
        fillStart  = (state == IDLE) && !d_wr_req && (d_miss || i_miss);
        startOwner = d_miss ? OWNER_D : OWNER_I;
        startBase  = (d_miss ? d_addr : i_addr) & BASE_MASK;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            QUIESCE: if (quiesceDone) nextState = IDLE;
            IDLE: begin
                if (d_wr_req) begin
                    nextState = STORE;
                end else if (d_miss) begin
                    nextState = FILL_D;
                end else if (i_miss) begin
                    nextState = FILL_I;
                end
            end
            STORE:   nextState = IDLE;
            FILL_D,
            FILL_I:  if (lastWord) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = QUIESCE;
        endcase
    end

    // Output logic: stores are driven straight from the request inputs, fill
    // reads come from the sequencer.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        d_wr_ack    = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        busy        = (state != IDLE);
        case (state)
            STORE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
            end
            FILL_D,
            FILL_I: begin
                mem_en   = seqIssueEn;
                mem_addr = seqIssueEn ? seqIssueAddr : '0;
            end
            DONE: begin
                i_fill_done = (fillOwner == OWNER_I);
                d_fill_done = (fillOwner == OWNER_D);
            end
            default: ;
        endcase
    end

    fill_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uFillSeq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (fillStart),
        .active     (fillActive),
        .base       (startBase),
        .owner      (startOwner),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .issueEn    (seqIssueEn),
        .issueAddr  (seqIssueAddr),
        .fill_data  (fill_data),
        .fill_word  (fill_word),
        .i_fill_we  (i_fill_we),
        .d_fill_we  (d_fill_we),
        .fillOwner  (fillOwner),
        .lastWord   (lastWord)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter. A pipelined memory model answers
// reads MEM_LAT cycles after issue; a transaction-level reference model
// predicts the order, cycle and content of every memory command, fill word
// and handshake pulse from the arbitration and latency rules.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [15:0] mem_rdata, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

    cache_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_miss      (i_miss),
        .i_addr      (i_addr),
        .d_miss      (d_miss),
        .d_addr      (d_addr),
        .d_wr_req    (d_wr_req),
        .d_wr_addr   (d_wr_addr),
        .d_wr_data   (d_wr_data),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fill_data   (fill_data),
        .fill_word   (fill_word),
        .i_fill_we   (i_fill_we),
        .d_fill_we   (d_fill_we),
        .i_fill_done (i_fill_done),
        .d_fill_done (d_fill_done),
        .d_wr_ack    (d_wr_ack),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int relCycle  = 0;

    // Memory pipeline and contents (environment side and reference side).
    logic        pv [MEM_LAT];
    logic [15:0] pd [MEM_LAT];
    logic [15:0] envMem [logic [15:0]];
    logic [15:0] refMem [logic [15:0]];

    // Event logs: {cycle, fields...} packed into 64 bits.
    logic [63:0] obsMem[$], expMem[$], obsFill[$], expFill[$], obsHs[$], expHs[$];

    // Snapshot of DUT outputs taken at the falling edge of the last cycle.
    logic        sMemEn, sMemWr, sIWe, sDWe, sIDone, sDDone, sAck, sBusy;
    logic [15:0] sMemAddr, sMemWdata, sFillData;
    logic [2:0]  sFillWord;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] envRead(input logic [15:0] a);
        return envMem.exists(a) ? envMem[a] : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : (a ^ 16'h5A5A);
    endfunction

    // One clock cycle: sample and log DUT outputs mid-cycle, act as memory,
    // then after the edge advance the read pipeline and drop any request whose
    // handshake pulse was seen.
    task automatic stepCycle();
        logic        newValid;
        logic [15:0] newData;
        @(negedge clk);
        sMemEn = mem_en;   sMemWr = mem_wr;   sMemAddr = mem_addr; sMemWdata = mem_wdata;
        sFillData = fill_data; sFillWord = fill_word; sIWe = i_fill_we; sDWe = d_fill_we;
        sIDone = i_fill_done; sDDone = d_fill_done; sAck = d_wr_ack; sBusy = busy;
        newValid = 1'b0;
        newData  = 16'h0;
        if (mem_en) begin
            if (mem_wr) begin
                envMem[mem_addr] = mem_wdata;
                obsMem.push_back({16'(relCycle), mem_addr, mem_wdata, 13'b0, 1'b1, 2'b00});
            end else begin
                newValid = 1'b1;
                newData  = envRead(mem_addr);
                obsMem.push_back({16'(relCycle), mem_addr, 16'h0, 13'b0, 1'b0, 2'b00});
            end
        end
        if (i_fill_we || d_fill_we)
            obsFill.push_back({16'(relCycle), 13'b0, fill_word, fill_data, 14'b0, i_fill_we, d_fill_we});
        if (d_wr_ack || i_fill_done || d_fill_done)
            obsHs.push_back({16'(relCycle), 32'h0, 13'b0, d_wr_ack, i_fill_done, d_fill_done});
        @(posedge clk);
        #1;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = newValid;
        pd[0] = newData;
        mem_rvalid = pv[MEM_LAT-1];
        mem_rdata  = pd[MEM_LAT-1];
        if (sAck)   d_wr_req = 1'b0;
        if (sIDone) i_miss   = 1'b0;
        if (sDDone) d_miss   = 1'b0;
        relCycle++;
    endtask

    // Expected events of one fill whose request is seen in IDLE at cycle t.
    task automatic predictFill(input bit isD, input logic [15:0] addr, input int t);
        logic [15:0] blockBase;
        logic [15:0] a;
        blockBase = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            a = blockBase + 16'(2 * k);
            expMem.push_back({16'(t + 1 + k), a, 16'h0, 13'b0, 1'b0, 2'b00});
            expFill.push_back({16'(t + 1 + k + MEM_LAT), 13'b0, 3'(k), refRead(a), 14'b0, !isD, isD});
        end
        expHs.push_back({16'(t + 9 + MEM_LAT), 32'h0, 13'b0, 1'b0, !isD, isD});
    endtask

    // Transaction-level schedule: at each IDLE cycle serve the highest
    // priority request already present; a store occupies 2 cycles up to the
    // next IDLE, a fill 10+MEM_LAT.
    task automatic modelPredict(input bit doStore, input int storeAt,
                                input logic [15:0] sAddr, input logic [15:0] sData,
                                input bit doD, input logic [15:0] dAddr,
                                input bit doI, input logic [15:0] iAddr,
                                output int lastCycle);
        bit pendS = doStore;
        bit pendD = doD;
        bit pendI = doI;
        int t = 0;
        lastCycle = 0;
        while (pendS || pendD || pendI) begin
            if (pendS && storeAt <= t) begin
                expMem.push_back({16'(t + 1), sAddr, sData, 13'b0, 1'b1, 2'b00});
                expHs.push_back({16'(t + 1), 32'h0, 13'b0, 1'b1, 1'b0, 1'b0});
                refMem[sAddr] = sData;
                lastCycle = t + 1;
                pendS = 1'b0;
                t += 2;
            end else if (pendD) begin
                predictFill(1'b1, dAddr, t);
                lastCycle = t + 9 + MEM_LAT;
                pendD = 1'b0;
                t += 10 + MEM_LAT;
            end else if (pendI) begin
                predictFill(1'b0, iAddr, t);
                lastCycle = t + 9 + MEM_LAT;
                pendI = 1'b0;
                t += 10 + MEM_LAT;
            end else begin
                t = storeAt;
            end
        end
    endtask

    task automatic compareLogs(input string tag);
        checkOutput({tag, " memOpCount"}, 64'(obsMem.size()), 64'(expMem.size()));
        for (int i = 0; i < expMem.size() && i < obsMem.size(); i++)
            checkOutput($sformatf("%s memOp%0d", tag, i), obsMem[i], expMem[i]);
        checkOutput({tag, " fillCount"}, 64'(obsFill.size()), 64'(expFill.size()));
        for (int i = 0; i < expFill.size() && i < obsFill.size(); i++)
            checkOutput($sformatf("%s fill%0d", tag, i), obsFill[i], expFill[i]);
        checkOutput({tag, " handshakeCount"}, 64'(obsHs.size()), 64'(expHs.size()));
        for (int i = 0; i < expHs.size() && i < obsHs.size(); i++)
            checkOutput($sformatf("%s handshake%0d", tag, i), obsHs[i], expHs[i]);
    endtask

    // Runs one scenario from an IDLE cycle (cycle 0) and checks every event.
    task automatic applyStimulus(input string tag, input bit doStore, input int storeAt,
                                 input logic [15:0] sAddr, input logic [15:0] sData,
                                 input bit doD, input logic [15:0] dAddr,
                                 input bit doI, input logic [15:0] iAddr);
        int lastCycle;
        obsMem.delete(); expMem.delete(); obsFill.delete(); expFill.delete();
        obsHs.delete();  expHs.delete();
        relCycle = 0;
        modelPredict(doStore, storeAt, sAddr, sData, doD, dAddr, doI, iAddr, lastCycle);
        d_addr = dAddr;
        i_addr = iAddr;
        d_wr_addr = sAddr;
        d_wr_data = sData;
        if (doD) d_miss = 1'b1;
        if (doI) i_miss = 1'b1;
        if (doStore && storeAt == 0) d_wr_req = 1'b1;
        while (relCycle <= lastCycle + 2) begin
            stepCycle();
            if (doStore && storeAt != 0 && relCycle == storeAt) d_wr_req = 1'b1;
        end
        compareLogs(tag);
        checkOutput({tag, " idleAtEnd"}, 64'(sBusy), 64'(0));
        d_miss = 1'b0;
        i_miss = 1'b0;
        d_wr_req = 1'b0;
    endtask

    function automatic logic [15:0] fillDataAt(input int idx);
        return (obsFill.size() > idx) ? obsFill[idx][31:16] : 16'hDEAD;
    endfunction

    function automatic logic [15:0] hsCycleAt(input int idx);
        return (obsHs.size() > idx) ? obsHs[idx][63:48] : 16'hFFFF;
    endfunction

    function automatic logic [15:0] memAddrAt(input int idx);
        return (obsMem.size() > idx) ? obsMem[idx][47:32] : 16'hDEAD;
    endfunction

    // Reset pulled for one cycle while read k=3 of a D fill is issuing.
    task automatic checkResetMidFill();
        logic [15:0] dA;
        obsMem.delete(); obsFill.delete(); obsHs.delete();
        relCycle = 0;
        dA = 16'($urandom);
        d_addr = dA;
        d_miss = 1'b1;
        repeat (4) stepCycle();
        rst_n = 1'b0;
        stepCycle();
        rst_n  = 1'b1;
        d_miss = 1'b0;
        for (int c = 0; c < MEM_LAT; c++) begin
            stepCycle();
            checkOutput($sformatf("rstMid quiesce%0d outputs", c),
                        64'({sMemEn, sMemWr, sMemAddr, sMemWdata, sFillWord,
                             sIWe, sDWe, sIDone, sDDone, sAck, sBusy}), 64'(1));
        end
        stepCycle();
        checkOutput("rstMid idleAfterQuiesce", 64'(sBusy), 64'(0));
        checkOutput("rstMid readsBeforeReset", 64'(obsMem.size()), 64'(4));
        checkOutput("rstMid staleFillWrites", 64'(obsFill.size()), 64'(0));
        checkOutput("rstMid handshakes", 64'(obsHs.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        bit rS, rD, rI;
        int sAt;
        logic [15:0] rdA, rsA;

        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end

        // Reset state: every output low except busy.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset outputs",
                    64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                         i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy}),
                    64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Quiesce lasts MEM_LAT cycles after reset release.
        busyCycles = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            if (!sBusy) break;
            busyCycles++;
        end
        checkOutput("quiesce length", 64'(busyCycles), 64'(MEM_LAT));

        // Plain I fill.
        applyStimulus("iFill", 0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 16'h0046);
        checkOutput("iFill word0 data", 64'(fillDataAt(0)), 64'(16'h5A1A));
        checkOutput("iFill word7 data", 64'(fillDataAt(7)), 64'(16'h5A14));
        checkOutput("iFill done cycle", 64'(hsCycleAt(0)), 64'(13));

        // D and I together: D first, one IDLE, then I.
        applyStimulus("dThenI", 0, 0, 16'h0, 16'h0, 1, 16'h1234, 1, 16'h0100);
        checkOutput("dThenI first I read", 64'(memAddrAt(8)), 64'(16'h0100));
        checkOutput("dThenI I done cycle", 64'(hsCycleAt(1)), 64'(27));

        // Store arriving mid I fill waits for the fill to finish.
        applyStimulus("storeMidFill", 1, 3, 16'h2000, 16'hBEEF, 0, 16'h0, 1, 16'h0100);
        checkOutput("storeMidFill ack cycle", 64'(hsCycleAt(1)), 64'(15));

        // Store then D miss to the same block: fill returns the new data.
        applyStimulus("storeThenFill", 1, 0, 16'h3004, 16'hCAFE, 1, 16'h3008, 0, 16'h0);
        checkOutput("storeThenFill word2", 64'(fillDataAt(2)), 64'(16'hCAFE));

        // Block at the top of memory wraps without carry.
        applyStimulus("wrapTop", 0, 0, 16'h0, 16'h0, 1, 16'hFFF8, 0, 16'h0);
        checkOutput("wrapTop first addr", 64'(memAddrAt(0)), 64'(16'hFFF0));
        checkOutput("wrapTop last addr", 64'(memAddrAt(7)), 64'(16'hFFFE));

        // Randomized request mixes.
        for (int n = 0; n < 25; n++) begin
            rS = 1'($urandom);
            rD = 1'($urandom);
            rI = 1'($urandom);
            if (!rS && !rD && !rI) rI = 1'b1;
            sAt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            rdA = 16'($urandom);
            rsA = ($urandom_range(0, 1) == 1) ? ((rdA & 16'hFFF0) + 16'(2 * $urandom_range(0, 7)))
                                              : (16'($urandom) & 16'hFFFE);
            applyStimulus($sformatf("rand%0d", n), rS, sAt, rsA, 16'($urandom),
                          rD, rdA, rI, 16'($urandom));
        end

        // Reset in the middle of a fill, then a clean I fill afterwards.
        checkResetMidFill();
        applyStimulus("afterReset", 0, 0, 16'h0, 16'h0, 0, 16'h0, 1, 16'($urandom));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single-port, pipelined main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between the two cache controllers and the main memory in the cpu top level.
- Sequences each fill as 8 back-to-back word reads and steers returned words into the requesting cache's data array with a word index.
- Arbitration is fixed priority, and a fill in progress is never pre-empted.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- WORDS, 8, words per cache block (16-byte block).
- MEM_LAT, 4, memory read latency in cycles; sets the post-reset quiesce length.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_miss  in  1  I-cache fill request; level, held until i_fill_done.
- i_addr  in  ADDR_W  I-cache miss address.
- d_miss  in  1  D-cache fill request; level, held until d_fill_done.
- d_addr  in  ADDR_W  D-cache miss address.
- d_wr_req  in  1  write-through store request; level, held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store address.
- d_wr_data  in  DATA_W  store data.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rvalid  in  1  read data valid (MEM_LAT cycles after issue).
- mem_rdata  in  DATA_W  read data.
- fill_data  out  DATA_W  equals mem_rdata.
- fill_word  out  3  word index of fill_data within the block.
- i_fill_we  out  1  write fill_data into the I-cache.
- d_fill_we  out  1  write fill_data into the D-cache.
- i_fill_done  out  1  one-cycle pulse: I fill complete.
- d_fill_done  out  1  one-cycle pulse: D fill complete.
- d_wr_ack  out  1  one-cycle pulse: store issued.
- busy  out  1  state is not IDLE.

Behaviour:
- States:
  - QUIESCE: entered on reset; waits MEM_LAT cycles.
  - IDLE.
  - STORE.
  - FILL_D.
  - FILL_I.
  - DONE: one cycle.
- Reset (rst_n=0 sampled at a rising edge):
  - State goes to QUIESCE and the quiesce counter is cleared.
  - Issue and return counters clear and the owner register clears.
  - All outputs are 0 except busy=1.
- QUIESCE:
  - Counts MEM_LAT cycles after rst_n rises, then goes to IDLE.
  - mem_rvalid is ignored, which drains any reads in flight.
  - No mem_en.
- IDLE arbitration, evaluated each cycle with priority d_wr_req > d_miss > i_miss:
  - d_wr_req wins: next state STORE.
  - d_miss wins: latch base = d_addr & ~0xF, owner = D, next state FILL_D.
  - i_miss wins: same with i_addr, owner = I, next state FILL_I.
  - No request: stay in IDLE.
  - Requests that lose stay pending and are re-evaluated after the current transaction returns to IDLE.
- STORE, exactly 1 cycle:
  - Drives mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data.
  - d_wr_ack=1 in the same cycle.
  - Next state IDLE.
- FILL_x issue phase:
  - Issue counter k runs 0..7.
  - Each cycle while k<8: mem_en=1, mem_wr=0, mem_addr = base + 2k (16-bit wrap, no carry out), then k increments.
  - Reads are issued back-to-back, 8 consecutive cycles.
- FILL_x return phase, concurrent with issue:
  - A return counter r runs 0..7.
  - On each mem_rvalid: fill_word=r, fill_data=mem_rdata, owner's fill_we=1, then r increments.
  - The non-owner's fill_we stays 0.
- FILL_x exit: when r==7 and mem_rvalid, the next state is DONE.
- DONE:
  - Owner's fill_done=1 for exactly one cycle.
  - No mem_en.
  - Next state IDLE.
  - The requester deasserts its miss in the cycle after the done pulse. The IDLE cycle that follows therefore ignores a miss still high in the DONE cycle.
- Fill latency: request seen in IDLE at cycle 0, FILL begins at 1, first read at 1, last read at 8, last word at 8+MEM_LAT, done at 9+MEM_LAT (13 with the default MEM_LAT).
- Stores arriving during a fill wait. A store followed by a D miss to the same block is ordered store first, so the fill returns the new data.
- Any mem_rvalid seen outside FILL_x is ignored. No fill_we is driven for it.
- Request inputs are not re-sampled during a fill; the latched base and owner are used throughout.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package:
  - State encoding: QUIESCE, IDLE, STORE, FILL_D, FILL_I, DONE.
  - WORDS, the block offset mask 0xFFF0, and the owner encoding (I=0, D=1).
- One sub-module, fill_sequencer:
  - Contains the issue and return counters, address generation and fill_word/fill_we steering.
  - Takes start, base and owner; produces last_word.
- The arbiter FSM instantiates fill_sequencer once and handles arbitration, STORE, QUIESCE and DONE.

Test Plan:
1. I-miss, i_addr=0x0046, memory word at addr A = A ^ 0x5A5A:
   - 8 reads at 0x0040..0x004E on consecutive cycles.
   - i_fill_we pulses with fill_word 0..7 and fill_data 0x5A1A..0x5A14.
   - i_fill_done at cycle 13.
   - d_fill_we stays 0 throughout.
2. d_miss and i_miss both asserted in IDLE, d_addr=0x1234, i_addr=0x0100:
   - D fill of 0x1230..0x123E completes first.
   - One IDLE cycle follows.
   - Then I fill of 0x0100..0x010E.
3. d_wr_req asserted mid I-fill (addr 0x2000, data 0xBEEF):
   - No write issued during the fill.
   - After i_fill_done, one STORE cycle with mem_wr=1, 0x2000/0xBEEF.
   - d_wr_ack pulses in that same cycle.
4. Store 0xCAFE to 0x3004, then d_miss to 0x3008 held simultaneously:
   - STORE precedes FILL_D.
   - The fill returns word 2 = 0xCAFE.
5. Wrap: d_addr=0xFFF8 → reads 0xFFF0..0xFFFE; no address beyond 0xFFFE.
6. rst_n low for one cycle at issue k=3 of a D fill:
   - All outputs clear.
   - 4 QUIESCE cycles follow; stale mem_rvalid produces no fill_we.
   - A new i_miss afterwards fills correctly from word 0.
